// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge/level capture, mask, fixed priority,
// in-service nesting and a single request/ack handshake toward the CPU.
module irq_ctrl #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    input  logic [N_SRC-1:0]  irq_in,
    output logic              int_req,
    output logic [ID_W-1:0]   int_id,
    input  logic              int_ack
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  mask_q, mask_d;
    logic [N_SRC-1:0]  mode_q, mode_d;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [N_SRC-1:0]  isr_q, isr_d;
    logic [N_SRC-1:0]  irq_prev_q, irq_prev_d;
    logic [ID_W-1:0]   int_id_q, int_id_d;

    logic [2:0]        sel;
    logic [N_SRC-1:0]  hi_mask, elig, w1c;
    logic              blocked, any_elig, id_elig, ack_ok, eoi_wr;
    logic [ID_W-1:0]   win_id;
    logic              unused_bits;

    assign sel         = Addr[2:0];
    assign unused_bits = ^{Addr[29:3], Din[31:N_SRC]};
    assign int_req     = (state_q == S_REQ);
    assign int_id      = int_id_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        isr_d      = isr_q;
        int_id_d   = int_id_q;
        irq_prev_d = irq_in;
        hi_mask    = '0;
        blocked    = 1'b0;
        win_id     = '0;
        id_elig    = 1'b0;

        // Only sources strictly above the highest-priority in-service one may interrupt.
        for (int i = 0; i < N_SRC; i++) begin
            if (isr_q[i]) blocked = 1'b1;
            hi_mask[i] = ~blocked;
        end
        elig     = pend_q & mask_q & hi_mask;
        any_elig = |elig;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win_id = ID_W'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (int_id_q == ID_W'(i)) id_elig = elig[i];
        end

        ack_ok = int_ack && (state_q == S_REQ);
        eoi_wr = WE && (sel == 3'd4);
        w1c    = (WE && (sel == 3'd2)) ? Din[N_SRC-1:0] : '0;

        if (WE && (sel == 3'd0)) mask_d = Din[N_SRC-1:0];
        if (WE && (sel == 3'd1)) mode_d = Din[N_SRC-1:0];

        for (int i = 0; i < N_SRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = (irq_in[i] & ~irq_prev_q[i]) |
                            (pend_q[i] & ~(w1c[i] | (ack_ok && (int_id_q == ID_W'(i)))));
            end else begin
                pend_d[i] = irq_in[i];
            end
            // Ack is applied after EOI so a same-cycle EOI+ack of one id leaves it in service.
            if (eoi_wr && (Din[ID_W-1:0] == ID_W'(i))) isr_d[i] = 1'b0;
            if (ack_ok && (int_id_q == ID_W'(i)))      isr_d[i] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    state_d  = S_REQ;
                    int_id_d = win_id;
                end
            end
            S_REQ: begin
                if (ack_ok || !id_elig) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Dout = '0;
        case (sel)
            3'd0: Dout[N_SRC-1:0] = mask_q;
            3'd1: Dout[N_SRC-1:0] = mode_q;
            3'd2: Dout[N_SRC-1:0] = pend_q;
            3'd3: Dout[N_SRC-1:0] = isr_q;
            3'd5: Dout = {int_req, {(31-ID_W){1'b0}}, int_id_q};
            default: Dout = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            isr_q      <= '0;
            irq_prev_q <= '0;
            int_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            isr_q      <= isr_d;
            irq_prev_q <= irq_prev_d;
            int_id_q   <= int_id_d;
        end
    end

endmodule
